// File: rtl/os2ip_pkg.sv
// Shared definitions for the octet-string-to-integer converter.
package os2ip_pkg;

  localparam int unsigned OCTET_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE,
    DRAIN
  } state_e;

endpackage

// File: rtl/os2ip_if.sv
// Octet input handshake plus converted-integer result bundle.
interface os2ip_if
  import os2ip_pkg::*;
#(
  parameter int unsigned DATA_BIT_WIDTH = 256
);

  logic                      in_valid;
  logic                      in_ready;
  logic [OCTET_WIDTH-1:0]    in_octet;
  logic                      in_last;
  logic [DATA_BIT_WIDTH-1:0] X;
  logic                      valid;
  logic                      err;

  modport master (
    output in_valid,
    output in_octet,
    output in_last,
    input  in_ready,
    input  X,
    input  valid,
    input  err
  );

  modport slave (
    input  in_valid,
    input  in_octet,
    input  in_last,
    output in_ready,
    output X,
    output valid,
    output err
  );

endinterface

// File: rtl/os2ip.sv
// Big-endian octet string to integer converter. Octets are shifted into an
// accumulator MSB-first; strings longer than the result width are rejected with
// a one-cycle err pulse and the remainder of the string is drained.
module os2ip
  import os2ip_pkg::*;
#(
  parameter int unsigned DATA_BIT_WIDTH = 256
) (
  input logic    clk,
  input logic    reset,
  os2ip_if.slave bus
);

  localparam int unsigned NUM_OCTETS   = DATA_BIT_WIDTH / OCTET_WIDTH;
  localparam logic [8:0]  NUM_OCTETS_C = 9'(NUM_OCTETS);

  state_e                    r_state;
  logic [DATA_BIT_WIDTH-1:0] r_acc;
  logic [DATA_BIT_WIDTH-1:0] r_x;
  logic [8:0]                r_count;
  logic                      r_valid;
  logic                      r_err;

  logic                      w_ready;
  logic                      w_accept;
  logic [DATA_BIT_WIDTH-1:0] w_acc_next;

  // Ready is forced low during reset and in the single result cycle.
  assign w_ready    = ~reset & (r_state != DONE);
  assign w_accept   = bus.in_valid & w_ready;
  assign w_acc_next = (r_acc << OCTET_WIDTH) | DATA_BIT_WIDTH'(bus.in_octet);

  // FSM, accumulator, octet counter and registered result/pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_x     <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc   <= w_acc_next;
            r_count <= 9'd1;
            if (bus.in_last) begin
              r_x     <= w_acc_next;
              r_valid <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_accept) begin
            if (r_count == NUM_OCTETS_C) begin
              // One octet too many: drop everything gathered so far.
              r_err   <= 1'b1;
              r_acc   <= '0;
              r_count <= '0;
              r_state <= bus.in_last ? IDLE : DRAIN;
            end else begin
              r_acc   <= w_acc_next;
              r_count <= r_count + 9'd1;
              if (bus.in_last) begin
                r_x     <= w_acc_next;
                r_valid <= 1'b1;
                r_state <= DONE;
              end
            end
          end
        end
        DONE: begin
          r_acc   <= '0;
          r_count <= '0;
          r_state <= IDLE;
        end
        DRAIN: begin
          // Swallow the tail of an oversized string without touching X.
          if (w_accept && bus.in_last) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.X        = r_x;
  assign bus.valid    = r_valid;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_os2ip.sv
// Self-checking bench for os2ip: directed scenarios plus randomized strings,
// gaps and resets, checked every cycle against a queue-based reference model.
module tb_os2ip;
  import os2ip_pkg::*;

  localparam int unsigned W    = 256;
  localparam int unsigned NOCT = W / 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  os2ip_if #(.DATA_BIT_WIDTH(W)) bus ();

  os2ip #(.DATA_BIT_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int valid_seen = 0;

  // Reference model state: octets of the current string, drain flag, expectations.
  logic [7:0]   m_q[$];
  bit           m_drain = 1'b0;
  logic [W-1:0] exp_x = '0;
  logic         exp_valid = 1'b0;
  logic         exp_err = 1'b0;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one clock edge to the model; hs says whether an octet was accepted.
  task automatic model_step(input bit hs, input logic [7:0] o, input bit l);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (reset) begin
      m_q.delete();
      m_drain = 1'b0;
      exp_x   = '0;
      return;
    end
    if (!hs) return;
    if (m_drain) begin
      if (l) m_drain = 1'b0;
      return;
    end
    m_q.push_back(o);
    if (m_q.size() > NOCT) begin
      exp_err = 1'b1;
      m_drain = !l;
      m_q.delete();
    end else if (l) begin
      exp_x = '0;
      foreach (m_q[i]) exp_x = (exp_x << 8) | W'(m_q[i]);
      exp_valid = 1'b1;
      m_q.delete();
    end
  endtask

  // One clock cycle: drive at negedge, step model at posedge, compare at next negedge.
  task automatic cycle(input bit v, input logic [7:0] o, input bit l, output bit hs);
    bit exp_ready;
    bus.in_valid = v;
    bus.in_octet = o;
    bus.in_last  = l;
    #1;
    hs = v && (bus.in_ready === 1'b1);
    @(posedge clk);
    model_step(hs, o, l);
    @(negedge clk);
    exp_ready = !reset && !exp_valid;
    check_val("valid", W'(bus.valid), W'(exp_valid));
    check_val("err", W'(bus.err), W'(exp_err));
    check_val("x", bus.X, exp_x);
    check_val("in_ready", W'(bus.in_ready), W'(exp_ready));
    if (bus.valid === 1'b1) valid_seen++;
  endtask

  task automatic idle(input int n);
    bit hs;
    repeat (n) cycle(1'b0, 8'($urandom), 1'($urandom), hs);
  endtask

  task automatic send_octet(input logic [7:0] o, input bit l, input int gap_pct);
    bit hs;
    int tries;
    while (int'($urandom_range(99)) < gap_pct) cycle(1'b0, 8'($urandom), 1'($urandom), hs);
    tries = 0;
    do begin
      cycle(1'b1, o, l, hs);
      tries++;
    end while (!hs && tries < 8);
    check_val("handshake", W'(hs), W'(1'b1));
  endtask

  task automatic send_string(input logic [7:0] s[$], input int gap_pct);
    foreach (s[i]) send_octet(s[i], (i == s.size() - 1), gap_pct);
  endtask

  task automatic pulse_reset();
    bit hs;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check_val("rst_x", bus.X, '0);
    check_val("rst_valid", W'(bus.valid), '0);
    check_val("rst_err", W'(bus.err), '0);
    check_val("rst_ready", W'(bus.in_ready), '0);
    cycle(1'b0, 8'h00, 1'b0, hs);
    reset = 1'b0;
    cycle(1'b0, 8'h00, 1'b0, hs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected bench completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]   s[$];
    logic [W-1:0] x_ref;
    int           len;
    int           gap;
    int           cut;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_octet = 8'h00;
    bus.in_last  = 1'b0;
    @(negedge clk);
    pulse_reset();

    // 32 octets 0x01..0x20 back to back.
    s = {};
    for (int i = 1; i <= 32; i++) s.push_back(8'(i));
    send_string(s, 0);
    check_val("req027_x", bus.X,
              256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20);
    idle(1);

    // Single octet, then a string with leading zeros.
    s = {8'hAB};
    send_string(s, 0);
    check_val("req028_ab", bus.X, 256'hAB);
    s = {8'h00, 8'h00, 8'h12, 8'h34};
    send_string(s, 0);
    check_val("req028_1234", bus.X, 256'h1234);
    idle(1);

    // 33 octets: overflow on the last one, X unchanged.
    s = {};
    for (int i = 0; i < 33; i++) s.push_back(8'hFF);
    send_string(s, 0);
    check_val("req029_err", W'(bus.err), W'(1'b1));
    idle(1);
    check_val("req029_x_kept", bus.X, 256'h1234);

    // 34 octets: err once, tail drained, then a short string works.
    s = {};
    for (int i = 0; i < 34; i++) s.push_back(8'($urandom));
    valid_seen = 0;
    send_string(s, 0);
    s = {8'h5A};
    send_string(s, 0);
    check_val("req030_x", bus.X, 256'h5A);
    check_val("req030_valid_cnt", W'(valid_seen), W'(1));
    idle(1);

    // Same 32-octet string with and without gaps.
    s = {};
    for (int i = 0; i < 32; i++) s.push_back(8'($urandom));
    send_string(s, 0);
    x_ref = exp_x;
    idle(2);
    valid_seen = 0;
    send_string(s, 40);
    idle(3);
    check_val("req031_x", bus.X, x_ref);
    check_val("req031_valid_cnt", W'(valid_seen), W'(1));

    // Reset mid-string, then a fresh one-octet string.
    for (int i = 0; i < 10; i++) send_octet(8'($urandom), 1'b0, 0);
    pulse_reset();
    s = {8'hC3};
    send_string(s, 0);
    check_val("req032_x", bus.X, 256'hC3);
    idle(1);

    // Random strings of varying length, gaps and occasional mid-string reset.
    for (int n = 0; n < 40; n++) begin
      len = int'($urandom_range(36, 1));
      gap = int'($urandom_range(40));
      s = {};
      for (int i = 0; i < len; i++) s.push_back(8'($urandom));
      if ($urandom_range(9) == 0) begin
        cut = int'($urandom_range(len - 1));
        for (int i = 0; i < cut; i++) send_octet(s[i], 1'b0, gap);
        pulse_reset();
      end else begin
        send_string(s, gap);
      end
      idle(int'($urandom_range(2)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/os2ip.md
OS2IP -- requirements
Module: os2ip

Interface
REQ-001 Parameter DATA_BIT_WIDTH, default 256: width of the integer result; SHALL be a multiple of 8.
REQ-002 Derived constant NUM_OCTETS = DATA_BIT_WIDTH/8 (32 at default): maximum accepted octet-string length.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_octet/in_last are presented this cycle.
REQ-006 in_ready  output  1  block can accept an octet this cycle.
REQ-007 in_octet  input  8  next octet, most-significant octet first (big-endian).
REQ-008 in_last  input  1  qualifies the final octet of the string.
REQ-009 X  output  DATA_BIT_WIDTH  converted integer, held until the next conversion completes.
REQ-010 valid  output  1  one-cycle pulse: X has just been updated.
REQ-011 err  output  1  one-cycle pulse: string longer than NUM_OCTETS ("integer too large"); the string is discarded.

Function
REQ-012 An octet SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; otherwise inputs are ignored.
REQ-013 The FSM SHALL have states IDLE, ACCUM, DONE and DRAIN.
REQ-014 On acceptance: acc <= {acc[DATA_BIT_WIDTH-9:0], in_octet}; count <= count+1, where count is a 9-bit saturating-safe counter.
REQ-015 IDLE: acc=0, count=0, in_ready=1. Acceptance with in_last=0 -> ACCUM. Acceptance with in_last=1 -> DONE.
REQ-016 ACCUM: in_ready=1. Acceptance with count<NUM_OCTETS and in_last=1 -> DONE. Acceptance with count<NUM_OCTETS and in_last=0 -> remain in ACCUM. Acceptance with count==NUM_OCTETS (overflow octet) -> err=1 on the next cycle and acc is discarded; in_last=1 -> IDLE, else -> DRAIN.
REQ-017 DONE: lasts exactly one cycle; X SHALL equal the final acc; valid=1; in_ready=0. Then -> IDLE with acc/count cleared.
REQ-018 Latency: valid SHALL rise exactly one cycle after the handshake of the last octet.
REQ-019 DRAIN: in_ready=1. Accepted octets are discarded and X is unchanged. Acceptance with in_last=1 -> IDLE. No further err pulses are produced.
REQ-020 Strings shorter than NUM_OCTETS SHALL yield a zero-extended integer, i.e. leading octets are implicitly zero. Leading zero octets in the string SHALL be legal.
REQ-021 valid and err SHALL never be asserted in the same cycle.
REQ-022 Gaps (in_valid=0) SHALL be legal in any state and SHALL not alter state.

Reset
REQ-023 Asserting reset (asynchronously, at any time, including mid-string) SHALL force: state=IDLE, acc=0, count=0, X=0, valid=0, err=0.
REQ-024 While reset is asserted, in_ready SHALL be 0, and no partial string SHALL survive reset.

Structure
REQ-025 Package os2ip_pkg SHALL hold the FSM state enumeration (IDLE, ACCUM, DONE, DRAIN) and the OCTET_WIDTH=8 constant.
REQ-026 The block is a single module with no sub-modules. The shift accumulator, counter and FSM are all local.

Verification
REQ-027 32 octets 0x01..0x20 back-to-back, in_last on 0x20 -> one cycle later valid=1, X=0x0102...1F20; in_ready=0 for that one cycle.
REQ-028 Single octet 0xAB with in_last=1 -> valid pulse, X=0x00...00AB. Then octets 0x00,0x00,0x12,0x34 (last) -> X=0x...1234.
REQ-029 33 octets of 0xFF, in_last on the 33rd -> err pulse one cycle after the 33rd handshake, no valid, X keeps its previous value, state returns to IDLE.
REQ-030 34-octet string -> err once, the 34th (last) octet is absorbed in DRAIN, and a following 1-octet string 0x5A -> valid, X=0x5A.
REQ-031 Random in_valid gaps across a 32-octet string -> X identical to the gap-free result, and valid occurs exactly once.
REQ-032 Reset asserted after 10 octets of a string, then a fresh string 0xC3 (last) is sent -> X=0xC3 with no residue from the earlier octets; all outputs are 0 during reset.
